ssd_bin2bcd: RTL and testbench
==============================

Name: ssd_bin2bcd

Overview:
- Sequential double-dabble converter between the CPU's 13-bit seven-segment value output and the seven-segment multiplexer.
- Converts an unsigned binary value to packed BCD digits so the display shows decimal.
- Iterative, one shift-and-adjust step per clock, with a start/busy/done handshake.
- Holds the last result stable for the display scanner between conversions.

Parameters:
- IN_W, 13, width of the binary input (13 bits gives a maximum of 8191).
- DIGITS, 4, number of BCD output digits (one per display anode).

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request conversion of bin_in; honoured only in IDLE or DONE.
- bin_in  input  IN_W  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and overflow are valid and updated.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- overflow  output  1  last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, internal shift/count registers cleared. Reset mid-conversion aborts it with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k → capture bin_in into the binary shift register, clear the BCD scratch register, count=0, go to SHIFT. busy=1 from edge k onward.
- SHIFT, one step per edge:
  - Every scratch digit ≥5 gets +3.
  - Shift the {scratch, binary} register left by 1.
  - The bit leaving the top digit's MSB ORs into a sticky overflow scratch flag.
  - count increments. After IN_W steps (edge k+IN_W) go to DONE.
- DONE entry (edge k+IN_W):
  - bcd_out ← scratch, or all digits 9 (saturate) when the overflow scratch flag is set.
  - overflow ← flag, done=1, busy=0.
- Latency: start accepted at edge k → done high in the cycle after edge k+IN_W, i.e. IN_W cycles. Default is 13.
- DONE lasts exactly one cycle. Next edge returns to IDLE with done=0, unless start=1, which is accepted as in IDLE (back-to-back; done drops, busy rises).
- start while in SHIFT is ignored and not queued. bin_in changes during SHIFT have no effect.
- bcd_out and overflow change only on the DONE-entry edge or on reset; otherwise they hold.
- Adjust rule: a digit value in 5..9 maps to 8..12 before the shift. Digits never exceed 9 after the shift, for non-overflow results.
- Overflow detection is exact: the flag is set iff bin_in ≥ 10^DIGITS. It is unreachable for the defaults and reachable for IN_W=14.
- No combinational path from start or bin_in to any output; all outputs are registered.

Decomposition:
- Shared package (ssd_pkg):
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - SSD_W=13 and SSD_DIGITS=4, so the CPU, this block and the seven-segment driver agree on widths.
  - BCD_NINE=4'd9.
- One natural sub-module: bcd_digit_adj.
  - Combinational: 4-bit digit in, digit+3 out if ≥5, else unchanged.
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset then bin_in=0, start pulse → done after 13 cycles, bcd_out=16'h0000, overflow=0, busy high for exactly 13 cycles.
- bin_in=8191 → bcd_out=16'h8191; bin_in=1234 → 16'h1234. Check done is a single-cycle pulse and bcd_out is unchanged until the next done.
- start held high for 40 cycles with bin_in=4095 → conversions back-to-back every 14 cycles, each done showing 16'h4095, no idle gap beyond the DONE cycle.
- start pulsed again at cycle 5 of a conversion with a different bin_in → ignored; only one done, with the original value's BCD.
- rst=0 asserted at cycle 7 of a conversion of 999 → next cycle busy=0, done=0, bcd_out=0; no done pulse follows.
- With IN_W=14: bin_in=12345 → overflow=1, bcd_out=16'h9999; then bin_in=9999 → overflow=0, bcd_out=16'h9999; then bin_in=10000 → overflow=1.

Source files
------------

// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display path. The CPU value
// register, the binary-to-BCD converter and the seven-segment driver all
// import this package so they agree on widths and encodings.
//
// Contents:
//   SSD_W, SSD_DIGITS   - binary value width and number of display digits
//   BCD_NINE            - digit value used when saturating the display
//   BCD_ADJ_MIN/ADD     - double-dabble adjust threshold and increment
//   ST_*                - converter FSM state encoding
// ---------------------------------------------------------------------------
package ssd_pkg;

    // Width of the CPU's seven-segment value output (max 8191).
    localparam int unsigned SSD_W      = 13;
    // One BCD digit per display anode.
    localparam int unsigned SSD_DIGITS = 4;

    localparam logic [3:0] BCD_NINE    = 4'd9;

    // A digit of 5..9 becomes 8..12 so that the following left shift
    // carries correctly into the next decimal digit.
    localparam logic [3:0] BCD_ADJ_MIN = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

    // Converter FSM encoding; kept as plain constants so legacy blocks that
    // decode the state bits keep working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble adjust for one BCD digit: adds 3 when the
// digit is 5 or more, otherwise passes it through unchanged.
//
// Ports:
//   i_digit  in   4  current scratch digit
//   o_digit  out  4  adjusted digit, ready to be shifted left
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import ssd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_MIN) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/ssd_bin2bcd.sv
// ---------------------------------------------------------------------------
// ssd_bin2bcd
// Iterative double-dabble converter sitting between the CPU's binary
// seven-segment value and the display multiplexer. One shift-and-adjust step
// is taken per clock; a conversion of an IN_W-bit value takes IN_W cycles.
// The last result is held on bcd_out/overflow until the next conversion
// completes, so the display scanner always sees a stable value.
//
// Parameters:
//   IN_W    width of the unsigned binary input
//   DIGITS  number of packed BCD output digits
//
// Ports:
//   clk       in   1         system clock
//   rst       in   1         synchronous active-low reset
//   start     in   1         request a conversion (accepted in IDLE or DONE)
//   bin_in    in   IN_W      value to convert, captured on the accepting edge
//   busy      out  1         conversion in progress
//   done      out  1         one-cycle pulse, bcd_out/overflow just updated
//   bcd_out   out  4*DIGITS  packed BCD, ones digit in bits [3:0]
//   overflow  out  1         last value did not fit in DIGITS digits
// ---------------------------------------------------------------------------
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int unsigned IN_W   = SSD_W,
    parameter int unsigned DIGITS = SSD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    // Count value seen on the edge that performs the final shift.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_W - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [IN_W-1:0]    r_bin;       // binary half of the shift register
    logic [BCD_W-1:0]   r_scratch;   // BCD half of the shift register
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf_flag;  // sticky: a bit fell off the top digit
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [IN_W-1:0]    w_bin_nxt;
    logic               w_carry_out;
    logic               w_ovf_flag_nxt;
    logic [BCD_W-1:0]   w_nines;
    logic               w_last_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Shift {adjusted scratch, binary} left by one. The MSB of the adjusted
    // top digit has nowhere to go; if it is ever set the value needs more
    // than DIGITS digits. Digit values only grow during a conversion, so
    // the sticky flag is exact: it is set iff bin_in >= 10**DIGITS.
    assign w_scratch_nxt  = {w_adj[BCD_W-2:0], r_bin[IN_W-1]};
    assign w_bin_nxt      = {r_bin[IN_W-2:0], 1'b0};
    assign w_carry_out    = w_adj[BCD_W-1];
    assign w_ovf_flag_nxt = r_ovf_flag | w_carry_out;

    assign w_nines     = {DIGITS{BCD_NINE}};
    assign w_last_step = (r_count == LAST_STEP);

    // -----------------------------------------------------------------------
    // Control FSM and registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE so that
                // back-to-back conversions lose only the DONE cycle.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_bin      <= bin_in;
                        r_scratch  <= '0;
                        r_count    <= '0;
                        r_ovf_flag <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end

                // start is deliberately ignored here; nothing is queued.
                ST_SHIFT: begin
                    r_scratch  <= w_scratch_nxt;
                    r_bin      <= w_bin_nxt;
                    r_ovf_flag <= w_ovf_flag_nxt;
                    r_count    <= r_count + CNT_W'(1);
                    if (w_last_step) begin
                        r_state <= ST_DONE;
                        // Saturate to all nines so the display never shows
                        // a silently truncated number.
                        r_bcd   <= w_ovf_flag_nxt ? w_nines : w_scratch_nxt;
                        r_ovf   <= w_ovf_flag_nxt;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decodes of registers, no path from start/bin_in.
    // -----------------------------------------------------------------------
    assign busy     = (r_state == ST_SHIFT);
    assign done     = (r_state == ST_DONE);
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_ssd_bin2bcd.sv
module tb_ssd_bin2bcd;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 13-bit input. DUT B: 14-bit input, overflow reachable.
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [12:0] bin_a = '0;
    logic [13:0] bin_b = '0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] bcd_a, bcd_b;

    ssd_bin2bcd u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .bin_in   (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd_out  (bcd_a),
        .overflow (ovf_a)
    );

    ssd_bin2bcd #(.IN_W(14), .DIGITS(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .bin_in   (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd_out  (bcd_b),
        .overflow (ovf_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboards and monitors (sample on negedge, inputs change at posedge+1)
    // -----------------------------------------------------------------------
    exp_t sb_a[$];
    exp_t sb_b[$];
    int   cyc = 0;
    int   dcnt_a = 0, dcnt_b = 0;
    int   dcyc_a[$];
    int   run_a = 0, run_b = 0;
    logic pdone_a = 1'b0, pdone_b = 1'b0;
    logic prst = 1'b0;
    exp_t hold_a = '{bcd: 16'h0, ovf: 1'b0};
    exp_t hold_b = '{bcd: 16'h0, ovf: 1'b0};

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        // Reset took effect on the posedge just passed: aborted work is lost.
        if (!prst) begin
            sb_a.delete();
            sb_b.delete();
            hold_a = '{bcd: 16'h0, ovf: 1'b0};
            hold_b = '{bcd: 16'h0, ovf: 1'b0};
        end

        if (done_a) begin
            dcnt_a++;
            dcyc_a.push_back(cyc);
            if (pdone_a) check("a_done_pulse", 32'(pdone_a), 32'd0);
            check("a_busy_len", 32'(run_a), 32'd13);
            if (sb_a.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_a.pop_front();
                check("a_bcd", 32'(bcd_a), 32'(e.bcd));
                check("a_ovf", 32'(ovf_a), 32'(e.ovf));
                hold_a = e;
            end
        end else begin
            check("a_hold", {15'd0, ovf_a, bcd_a}, {15'd0, hold_a.ovf, hold_a.bcd});
        end

        if (done_b) begin
            dcnt_b++;
            if (pdone_b) check("b_done_pulse", 32'(pdone_b), 32'd0);
            check("b_busy_len", 32'(run_b), 32'd14);
            if (sb_b.size() == 0) begin
                check("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_b.pop_front();
                check("b_bcd", 32'(bcd_b), 32'(e.bcd));
                check("b_ovf", 32'(ovf_b), 32'(e.ovf));
                hold_b = e;
            end
        end else begin
            check("b_hold", {15'd0, ovf_b, bcd_b}, {15'd0, hold_b.ovf, hold_b.bcd});
        end

        run_a   = busy_a ? run_a + 1 : 0;
        run_b   = busy_b ? run_b + 1 : 0;
        pdone_a = done_a;
        pdone_b = done_b;
        prst    = rst;
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv_a(input logic [12:0] v, input logic [15:0] bcd, input logic ovf);
        bin_a   = v;
        start_a = 1'b1;
        sb_a.push_back('{bcd: bcd, ovf: ovf});
        tick();
        start_a = 1'b0;
    endtask

    task automatic start_conv_b(input logic [13:0] v, input logic [15:0] bcd, input logic ovf);
        bin_b   = v;
        start_b = 1'b1;
        sb_b.push_back('{bcd: bcd, ovf: ovf});
        tick();
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && sb_b.size() == 0 && !busy_a && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("timeout_wait_idle", 32'd1, 32'd0);
        tick();
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    vec_t tbl_a[8];
    vec_t tbl_b[5];

    initial begin
        int d0;

        tbl_a[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
        tbl_a[1] = '{bin: 14'd8191,  bcd: 16'h8191, ovf: 1'b0};
        tbl_a[2] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
        tbl_a[3] = '{bin: 14'd9,     bcd: 16'h0009, ovf: 1'b0};
        tbl_a[4] = '{bin: 14'd10,    bcd: 16'h0010, ovf: 1'b0};
        tbl_a[5] = '{bin: 14'd999,   bcd: 16'h0999, ovf: 1'b0};
        tbl_a[6] = '{bin: 14'd5005,  bcd: 16'h5005, ovf: 1'b0};
        tbl_a[7] = '{bin: 14'd7777,  bcd: 16'h7777, ovf: 1'b0};

        tbl_b[0] = '{bin: 14'd12345, bcd: 16'h9999, ovf: 1'b1};
        tbl_b[1] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
        tbl_b[2] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
        tbl_b[3] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
        tbl_b[4] = '{bin: 14'd4321,  bcd: 16'h4321, ovf: 1'b0};

        // Reset
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_bcd_a",  32'(bcd_a),  32'd0);
        check("rst_ovf_a",  32'(ovf_a),  32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_bcd_b",  32'(bcd_b),  32'd0);
        tick();

        // Table-driven conversions, one at a time
        for (int i = 0; i < 8; i++) begin
            d0 = dcnt_a;
            start_conv_a(tbl_a[i].bin[12:0], tbl_a[i].bcd, tbl_a[i].ovf);
            wait_idle(40);
            check("a_done_count", 32'(dcnt_a - d0), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            d0 = dcnt_b;
            start_conv_b(tbl_b[i].bin, tbl_b[i].bcd, tbl_b[i].ovf);
            wait_idle(40);
            check("b_done_count", 32'(dcnt_b - d0), 32'd1);
        end

        // start held for 40 cycles: accepts at 0, 14, 28 -> three dones
        repeat (3) tick();
        dcyc_a.delete();
        d0 = dcnt_a;
        bin_a   = 13'd4095;
        start_a = 1'b1;
        repeat (3) sb_a.push_back('{bcd: 16'h4095, ovf: 1'b0});
        repeat (40) tick();
        start_a = 1'b0;
        wait_idle(60);
        check("b2b_done_count", 32'(dcnt_a - d0), 32'd3);
        if (dcyc_a.size() == 3) begin
            check("b2b_gap1", 32'(dcyc_a[1] - dcyc_a[0]), 32'd14);
            check("b2b_gap2", 32'(dcyc_a[2] - dcyc_a[1]), 32'd14);
        end else begin
            check("b2b_done_log", 32'(dcyc_a.size()), 32'd3);
        end

        // start during SHIFT is ignored and not queued
        d0 = dcnt_a;
        start_conv_a(13'd1234, 16'h1234, 1'b0);
        repeat (4) tick();
        bin_a   = 13'd777;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_idle(60);
        repeat (20) tick();
        check("ignored_start_dones", 32'(dcnt_a - d0), 32'd1);

        // Reset mid-conversion aborts with no done
        d0 = dcnt_a;
        start_conv_a(13'd999, 16'h0999, 1'b0);
        repeat (6) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_bcd",  32'(bcd_a),  32'd0);
        check("abort_ovf",  32'(ovf_a),  32'd0);
        repeat (25) tick();
        check("abort_no_done", 32'(dcnt_a - d0), 32'd0);

        // Conversion after the abort still works
        start_conv_a(13'd2024, 16'h2024, 1'b0);
        wait_idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, want finish");
        $fatal(1, "global timeout");
    end

endmodule
